// File: rtl/operand_fetch_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : operand_fetch_ctrl_if
//  Description : Bundle of decode, register-file, write-back and execute
//                signals around the operand fetch controller.
//                master : environment side (decode / regfile / execute)
//                slave  : operand_fetch_ctrl side
//  Ports       : in_valid/in_ready/opcode/rs1_addr/rs2_addr  decode handshake
//                rf_re/rf_raddr/rf_rdata                      regfile read port
//                wb_en/wb_addr/wb_data                        write-back snoop
//                out_valid/out_ready/opcode_out/rs1_data/rs2_data  execute
//  Revision    : 1.0 - initial release
// ============================================================================
interface operand_fetch_ctrl_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5
);
    logic            in_valid;
    logic            in_ready;
    logic [6:0]      opcode;
    logic [AW-1:0]   rs1_addr;
    logic [AW-1:0]   rs2_addr;
    logic            rf_re;
    logic [AW-1:0]   rf_raddr;
    logic [XLEN-1:0] rf_rdata;
    logic            wb_en;
    logic [AW-1:0]   wb_addr;
    logic [XLEN-1:0] wb_data;
    logic            out_valid;
    logic            out_ready;
    logic [6:0]      opcode_out;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;

    modport master (
        output in_valid, opcode, rs1_addr, rs2_addr,
        input  in_ready,
        input  rf_re, rf_raddr,
        output rf_rdata,
        output wb_en, wb_addr, wb_data,
        input  out_valid, opcode_out, rs1_data, rs2_data,
        output out_ready
    );

    modport slave (
        input  in_valid, opcode, rs1_addr, rs2_addr,
        output in_ready,
        output rf_re, rf_raddr,
        input  rf_rdata,
        input  wb_en, wb_addr, wb_data,
        output out_valid, opcode_out, rs1_data, rs2_data,
        input  out_ready
    );
endinterface
`default_nettype wire

// File: rtl/operand_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : operand_fetch_ctrl
//  Description : Fetches rs1 then rs2 for one decoded instruction over a
//                single shared register-file read port, forwarding and
//                snooping write-back data, and holds both operands for
//                execute until consumed.
//  Ports       : clk  - clock
//                rst  - synchronous active-low reset
//                bus  - operand_fetch_ctrl_if.slave (decode, regfile,
//                       write-back and execute signals)
//  Revision    : 1.0 - initial release
// ============================================================================
module operand_fetch_ctrl #(
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic                clk,
    input  logic                rst,
    operand_fetch_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD1  = 2'd1,
        S_RD2  = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_next;

    logic [6:0]      r_opcode;
    logic [AW-1:0]   r_rs1_addr;
    logic [AW-1:0]   r_rs2_addr;
    logic            r_need_rs1;
    logic            r_need_rs2;
    logic [XLEN-1:0] r_rs1_data;
    logic [XLEN-1:0] r_rs2_data;

    logic            w_in_need_rs1;
    logic            w_in_need_rs2;
    logic            w_in_ready;
    logic            w_out_valid;
    logic            w_rf_re;
    logic [AW-1:0]   w_rf_raddr;
    logic [XLEN-1:0] w_capture;
    logic            w_snoop_rs1;
    logic            w_snoop_rs2;

    // Operand classes keyed on opcode[6:2] (RV32 major opcode).
    function automatic logic uses_rs1(input logic [4:0] major);
        case (major)
            5'b01100, 5'b00000, 5'b00100,
            5'b11001, 5'b01000, 5'b11000: return 1'b1;
            default:                      return 1'b0;
        endcase
    endfunction

    function automatic logic uses_rs2(input logic [4:0] major);
        case (major)
            5'b01100, 5'b01000, 5'b11000: return 1'b1;
            default:                      return 1'b0;
        endcase
    endfunction

    // x0 reads are skipped entirely; the operand simply stays at zero.
    assign w_in_need_rs1 = uses_rs1(bus.opcode[6:2]) && (bus.rs1_addr != '0);
    assign w_in_need_rs2 = uses_rs2(bus.opcode[6:2]) && (bus.rs2_addr != '0);

    // Write-back in the same cycle as the read wins over the stale regfile.
    assign w_capture = (bus.wb_en && (bus.wb_addr == w_rf_raddr)) ? bus.wb_data
                                                                   : bus.rf_rdata;

    // Keep already-fetched operands current until execute consumes them.
    assign w_snoop_rs1 = bus.wb_en && (bus.wb_addr != '0) &&
                         (bus.wb_addr == r_rs1_addr) && r_need_rs1;
    assign w_snoop_rs2 = bus.wb_en && (bus.wb_addr != '0) &&
                         (bus.wb_addr == r_rs2_addr) && r_need_rs2;

    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        w_out_valid  = 1'b0;
        w_rf_re      = 1'b0;
        w_rf_raddr   = '0;
        case (r_state)
            S_IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    if (w_in_need_rs1)      w_state_next = S_RD1;
                    else if (w_in_need_rs2) w_state_next = S_RD2;
                    else                    w_state_next = S_HOLD;
                end
            end
            S_RD1: begin
                w_rf_re      = 1'b1;
                w_rf_raddr   = r_rs1_addr;
                w_state_next = r_need_rs2 ? S_RD2 : S_HOLD;
            end
            S_RD2: begin
                w_rf_re      = 1'b1;
                w_rf_raddr   = r_rs2_addr;
                w_state_next = S_HOLD;
            end
            S_HOLD: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_opcode   <= '0;
            r_rs1_addr <= '0;
            r_rs2_addr <= '0;
            r_need_rs1 <= 1'b0;
            r_need_rs2 <= 1'b0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_opcode   <= bus.opcode;
                        r_rs1_addr <= bus.rs1_addr;
                        r_rs2_addr <= bus.rs2_addr;
                        r_need_rs1 <= w_in_need_rs1;
                        r_need_rs2 <= w_in_need_rs2;
                        r_rs1_data <= '0;
                        r_rs2_data <= '0;
                    end
                end
                S_RD1: begin
                    r_rs1_data <= w_capture;
                end
                S_RD2: begin
                    r_rs2_data <= w_capture;
                    if (w_snoop_rs1) r_rs1_data <= bus.wb_data;
                end
                S_HOLD: begin
                    if (w_snoop_rs1) r_rs1_data <= bus.wb_data;
                    if (w_snoop_rs2) r_rs2_data <= bus.wb_data;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = w_out_valid;
    assign bus.rf_re      = w_rf_re;
    assign bus.rf_raddr   = w_rf_raddr;
    assign bus.opcode_out = r_opcode;
    assign bus.rs1_data   = r_rs1_data;
    assign bus.rs2_data   = r_rs2_data;

endmodule
`default_nettype wire

// File: tb/tb_operand_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_operand_fetch_ctrl
//  Description : Self-checking bench for operand_fetch_ctrl: vector table,
//                directed corner sequences and randomized traffic against
//                an architectural register-file model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_operand_fetch_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    operand_fetch_ctrl_if #(.XLEN(32), .AW(5)) bus_if ();

    operand_fetch_ctrl #(.XLEN(32), .AW(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    // Architectural register file; write-back lands at the clock edge.
    logic [31:0] regs [32];
    assign bus_if.rf_rdata = regs[bus_if.rf_raddr];

    int n_cmp = 0;
    int n_bad = 0;
    bit rand_wb = 1'b0;

    typedef struct {
        logic [6:0]  op;
        logic [4:0]  a1, a2;
        int          lat, nrd;
        logic [4:0]  ra0, ra1;
        logic [31:0] d1, d2;
    } vec_t;
    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        if (rand_wb) begin
            bus_if.wb_en   = ($urandom_range(0, 2) == 0);
            bus_if.wb_addr = 5'($urandom_range(0, 7));
            bus_if.wb_data = $urandom;
        end
        @(posedge clk);
        #1;
        if (bus_if.wb_en && bus_if.wb_addr != 5'd0) regs[bus_if.wb_addr] = bus_if.wb_data;
    endtask

    // Accept one instruction and run until out_valid (bounded).
    task automatic issue(input logic [6:0] op, input logic [4:0] a1, input logic [4:0] a2,
                         output int lat, output int nrd,
                         output logic [4:0] ra0, output logic [4:0] ra1);
        int guard = 0;
        while (!bus_if.in_ready && guard < 20) begin
            step();
            guard++;
        end
        chk("in_ready_idle", 32'(bus_if.in_ready), 32'd1);
        bus_if.in_valid = 1'b1;
        bus_if.opcode   = op;
        bus_if.rs1_addr = a1;
        bus_if.rs2_addr = a2;
        step();
        bus_if.in_valid = 1'b0;
        bus_if.rs1_addr = 5'($urandom);
        bus_if.rs2_addr = 5'($urandom);
        bus_if.opcode   = 7'($urandom);
        lat = 1; nrd = 0; ra0 = '0; ra1 = '0;
        while (!bus_if.out_valid && lat < 8) begin
            if (bus_if.rf_re) begin
                if (nrd == 0) ra0 = bus_if.rf_raddr;
                else          ra1 = bus_if.rf_raddr;
                nrd++;
            end
            step();
            lat++;
        end
        chk("out_valid_reached", 32'(bus_if.out_valid), 32'd1);
        chk("in_ready_in_hold", 32'(bus_if.in_ready), 32'd0);
    endtask

    task automatic consume();
        bus_if.out_ready = 1'b1;
        step();
        bus_if.out_ready = 1'b0;
        chk("out_valid_after_consume", 32'(bus_if.out_valid), 32'd0);
        chk("in_ready_after_consume", 32'(bus_if.in_ready), 32'd1);
    endtask

    function automatic bit m_rs1(input logic [6:0] op);
        return op[6:2] inside {5'b01100, 5'b00000, 5'b00100, 5'b11001, 5'b01000, 5'b11000};
    endfunction
    function automatic bit m_rs2(input logic [6:0] op);
        return op[6:2] inside {5'b01100, 5'b01000, 5'b11000};
    endfunction
    function automatic logic [6:0] pick_op(input int k);
        case (k)
            0: return 7'b0110011;
            1: return 7'b0010011;
            2: return 7'b0000011;
            3: return 7'b0100011;
            4: return 7'b1100011;
            5: return 7'b1100111;
            6: return 7'b0110111;
            7: return 7'b0010111;
            8: return 7'b1101111;
            default: return 7'($urandom);
        endcase
    endfunction

    initial begin
        int lat, nrd;
        logic [4:0] ra0, ra1;

        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int lat, nrd;
        logic [4:0] ra0, ra1;

        bus_if.in_valid = 1'b0; bus_if.opcode = '0;
        bus_if.rs1_addr = '0;   bus_if.rs2_addr = '0;
        bus_if.wb_en = 1'b0;    bus_if.wb_addr = '0; bus_if.wb_data = '0;
        bus_if.out_ready = 1'b0;
        for (int i = 0; i < 32; i++) regs[i] = (i == 0) ? 32'd0 : 32'hA000_0000 + 32'(i);

        // ---------------- reset state ----------------
        rst = 1'b0;
        step(); step();
        rst = 1'b1;
        chk("rst_out_valid", 32'(bus_if.out_valid), 32'd0);
        chk("rst_in_ready", 32'(bus_if.in_ready), 32'd1);
        chk("rst_rf_re", 32'(bus_if.rf_re), 32'd0);
        chk("rst_rf_raddr", 32'(bus_if.rf_raddr), 32'd0);
        chk("rst_rs1", bus_if.rs1_data, 32'd0);
        chk("rst_rs2", bus_if.rs2_data, 32'd0);
        chk("rst_opcode", 32'(bus_if.opcode_out), 32'd0);

        // ---------------- vector table ----------------
        vecs[0]  = '{7'b0110011, 5'd3,  5'd5,  3, 2, 5'd3,  5'd5,  32'hA000_0003, 32'hA000_0005};
        vecs[1]  = '{7'b0010011, 5'd7,  5'd9,  2, 1, 5'd7,  5'd0,  32'hA000_0007, 32'h0};
        vecs[2]  = '{7'b0110111, 5'd4,  5'd6,  1, 0, 5'd0,  5'd0,  32'h0,         32'h0};
        vecs[3]  = '{7'b0110011, 5'd0,  5'd0,  1, 0, 5'd0,  5'd0,  32'h0,         32'h0};
        vecs[4]  = '{7'b0100011, 5'd0,  5'd8,  2, 1, 5'd8,  5'd0,  32'h0,         32'hA000_0008};
        vecs[5]  = '{7'b1100011, 5'd10, 5'd10, 3, 2, 5'd10, 5'd10, 32'hA000_000A, 32'hA000_000A};
        vecs[6]  = '{7'b0000011, 5'd31, 5'd2,  2, 1, 5'd31, 5'd0,  32'hA000_001F, 32'h0};
        vecs[7]  = '{7'b1100111, 5'd1,  5'd12, 2, 1, 5'd1,  5'd0,  32'hA000_0001, 32'h0};
        vecs[8]  = '{7'b0010111, 5'd3,  5'd5,  1, 0, 5'd0,  5'd0,  32'h0,         32'h0};
        vecs[9]  = '{7'b1101111, 5'd3,  5'd5,  1, 0, 5'd0,  5'd0,  32'h0,         32'h0};
        vecs[10] = '{7'b1111111, 5'd3,  5'd5,  1, 0, 5'd0,  5'd0,  32'h0,         32'h0};
        vecs[11] = '{7'b0110011, 5'd6,  5'd0,  2, 1, 5'd6,  5'd0,  32'hA000_0006, 32'h0};
        for (int v = 0; v < 12; v++) begin
            issue(vecs[v].op, vecs[v].a1, vecs[v].a2, lat, nrd, ra0, ra1);
            chk($sformatf("vec%0d_latency", v), 32'(lat), 32'(vecs[v].lat));
            chk($sformatf("vec%0d_reads", v), 32'(nrd), 32'(vecs[v].nrd));
            chk($sformatf("vec%0d_raddr0", v), 32'(ra0), 32'(vecs[v].ra0));
            chk($sformatf("vec%0d_raddr1", v), 32'(ra1), 32'(vecs[v].ra1));
            chk($sformatf("vec%0d_opcode", v), 32'(bus_if.opcode_out), 32'(vecs[v].op));
            chk($sformatf("vec%0d_rs1", v), bus_if.rs1_data, vecs[v].d1);
            chk($sformatf("vec%0d_rs2", v), bus_if.rs2_data, vecs[v].d2);
            chk($sformatf("vec%0d_rf_re_hold", v), 32'(bus_if.rf_re), 32'd0);
            consume();
        end

        // ---------------- directed: example R-type and op-imm ----------------
        regs[3] = 32'h11; regs[5] = 32'h22; regs[7] = 32'hABCD;
        issue(7'b0110011, 5'd3, 5'd5, lat, nrd, ra0, ra1);
        chk("rtype_lat", 32'(lat), 32'd3);
        chk("rtype_rs1", bus_if.rs1_data, 32'h11);
        chk("rtype_rs2", bus_if.rs2_data, 32'h22);
        consume();
        issue(7'b0010011, 5'd7, 5'd0, lat, nrd, ra0, ra1);
        chk("opimm_lat", 32'(lat), 32'd2);
        chk("opimm_reads", 32'(nrd), 32'd1);
        chk("opimm_rs1", bus_if.rs1_data, 32'hABCD);
        chk("opimm_rs2", bus_if.rs2_data, 32'h0);
        consume();

        // ---------------- directed: forward during RD1 ----------------
        regs[4] = 32'h99;
        bus_if.in_valid = 1'b1; bus_if.opcode = 7'b0110011;
        bus_if.rs1_addr = 5'd4; bus_if.rs2_addr = 5'd0;
        step();
        bus_if.in_valid = 1'b0;
        chk("fwd_in_rd1", 32'(bus_if.rf_raddr), 32'd4);
        bus_if.wb_en = 1'b1; bus_if.wb_addr = 5'd4; bus_if.wb_data = 32'h55;
        step();
        bus_if.wb_en = 1'b0;
        chk("fwd_out_valid", 32'(bus_if.out_valid), 32'd1);
        chk("fwd_rs1", bus_if.rs1_data, 32'h55);
        consume();

        // ---------------- directed: snoop in HOLD ----------------
        issue(7'b0110011, 5'd3, 5'd5, lat, nrd, ra0, ra1);
        bus_if.wb_en = 1'b1; bus_if.wb_addr = 5'd5; bus_if.wb_data = 32'h77;
        step();
        bus_if.wb_en = 1'b0;
        chk("snoop_still_valid", 32'(bus_if.out_valid), 32'd1);
        chk("snoop_rs2", bus_if.rs2_data, 32'h77);
        chk("snoop_rs1_kept", bus_if.rs1_data, 32'h11);
        step();
        chk("snoop_hold_wait", 32'(bus_if.out_valid), 32'd1);
        consume();

        // ---------------- directed: reset during RD2 ----------------
        bus_if.in_valid = 1'b1; bus_if.opcode = 7'b0110011;
        bus_if.rs1_addr = 5'd3; bus_if.rs2_addr = 5'd5;
        step();
        bus_if.in_valid = 1'b0;
        step();
        chk("rst_mid_in_rd2", 32'(bus_if.rf_raddr), 32'd5);
        rst = 1'b0;
        step();
        chk("rst_mid_out_valid", 32'(bus_if.out_valid), 32'd0);
        chk("rst_mid_rf_re", 32'(bus_if.rf_re), 32'd0);
        chk("rst_mid_rf_raddr", 32'(bus_if.rf_raddr), 32'd0);
        chk("rst_mid_rs1", bus_if.rs1_data, 32'd0);
        chk("rst_mid_rs2", bus_if.rs2_data, 32'd0);
        chk("rst_mid_opcode", 32'(bus_if.opcode_out), 32'd0);
        chk("rst_mid_in_ready", 32'(bus_if.in_ready), 32'd1);
        rst = 1'b1;
        issue(7'b0010011, 5'd7, 5'd0, lat, nrd, ra0, ra1);
        chk("post_rst_lat", 32'(lat), 32'd2);
        chk("post_rst_rs1", bus_if.rs1_data, 32'hABCD);
        consume();

        // ---------------- randomized traffic vs architectural model ----------------
        rand_wb = 1'b1;
        for (int it = 0; it < 200; it++) begin
            logic [6:0] op;
            logic [4:0] a1, a2;
            bit n1, n2;
            int hold;
            op = pick_op($urandom_range(0, 9));
            a1 = 5'($urandom_range(0, 7));
            a2 = 5'($urandom_range(0, 7));
            n1 = m_rs1(op) && (a1 != 5'd0);
            n2 = m_rs2(op) && (a2 != 5'd0);
            issue(op, a1, a2, lat, nrd, ra0, ra1);
            chk("rnd_latency", 32'(lat), 32'(1 + int'(n1) + int'(n2)));
            chk("rnd_reads", 32'(nrd), 32'(int'(n1) + int'(n2)));
            if (n1) chk("rnd_raddr_rs1", 32'(ra0), 32'(a1));
            if (n2) chk("rnd_raddr_rs2", 32'(n1 ? ra1 : ra0), 32'(a2));
            chk("rnd_opcode", 32'(bus_if.opcode_out), 32'(op));
            hold = $urandom_range(0, 3);
            for (int h = 0; h <= hold; h++) begin
                if (h != 0) step();
                chk("rnd_hold_valid", 32'(bus_if.out_valid), 32'd1);
                chk("rnd_rs1", bus_if.rs1_data, n1 ? regs[a1] : 32'd0);
                chk("rnd_rs2", bus_if.rs2_data, n2 ? regs[a2] : 32'd0);
            end
            consume();
        end
        rand_wb = 1'b0;
        bus_if.wb_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/operand_fetch_ctrl.md
Name: operand_fetch_ctrl

Overview:
Sequences operand fetch for one decoded instruction over a single shared register-file read port. It loads the rs1 operand register and then the rs2 operand register, and holds both for the execute stage. It sits between decode and execute: it accepts an instruction with a valid/ready handshake, issues one register-file read per cycle, and forwards write-back data on address match. Both operands are then presented to execute with a valid/ready handshake.

Parameters:
XLEN, 32, operand/data width
AW, 5, register address width

Ports:
clk  input  1  clock
rst  input  1  synchronous active-low reset
in_valid  input  1  decode presents an instruction
in_ready  output  1  block can accept (high only in IDLE)
opcode  input  7  instruction opcode
rs1_addr  input  AW  source register 1 index
rs2_addr  input  AW  source register 2 index
rf_re  output  1  register-file read enable
rf_raddr  output  AW  register-file read address
rf_rdata  input  XLEN  register-file read data, combinational from rf_raddr
wb_en  input  1  write-back strobe
wb_addr  input  AW  write-back register index
wb_data  input  XLEN  write-back data
out_valid  output  1  operands ready for execute
out_ready  input  1  execute consumes operands
opcode_out  output  7  latched opcode
rs1_data  output  XLEN  rs1 operand
rs2_data  output  XLEN  rs2 operand

Behaviour:
- Reset: rst low at a clk edge forces the following; this also applies mid-operation, and any in-flight instruction is dropped.
  - state=IDLE
  - out_valid=0, rf_re=0, rf_raddr=0
  - rs1_data=0, rs2_data=0, opcode_out=0
- Operand classes, decoded from the latched opcode:
  - needs_rs1: opcode[6:2] in {01100 R, 00000 load, 00100 op-imm, 11001 jalr, 01000 store, 11000 branch}.
  - needs_rs2: opcode[6:2] in {01100, 01000, 11000}.
  - Any other opcode (lui/auipc/jal/unknown) needs neither operand.
- Effective need for each source = class need AND address!=0. An address of 0 skips its read cycle and forces that operand to 0.
- FSM states: IDLE, RD1, RD2, HOLD.
  - IDLE: in_ready=1. On in_valid, latch opcode/addresses and clear rs1_data/rs2_data. Next state is RD1 if rs1 is needed, else RD2 if rs2 is needed, else HOLD.
  - RD1: rf_re=1, rf_raddr=rs1 address. At the clk edge capture rs1_data. Next state is RD2 if rs2 is needed, else HOLD.
  - RD2: rf_re=1, rf_raddr=rs2 address. At the clk edge capture rs2_data. Next state is HOLD.
  - HOLD: out_valid=1. On out_ready go to IDLE (out_valid low next cycle).
- rf_re and rf_raddr are combinational from state and latched addresses. rf_raddr=0 when rf_re=0.
- Capture rule in RD1/RD2: if wb_en and wb_addr equals the read address, capture wb_data; otherwise capture rf_rdata.
- Snoop rule in RD2 and HOLD: if wb_en, wb_addr!=0 and wb_addr equals the latched rs1 address (rs1 needed), rs1_data is updated to wb_data. The same rule applies in HOLD for rs2. Operands never go stale before consumption.
- Latency from acceptance edge to out_valid:
  - 3 cycles with both operands needed.
  - 2 cycles with one operand needed.
  - 1 cycle with none needed.
- Throughput: one bubble cycle between consumption and the next acceptance, because in_ready is high only in IDLE.
- opcode_out, rs1_data and rs2_data are stable while out_valid=1, except for snoop updates.
- The same register used as both rs1 and rs2: two read cycles still occur, and both operands receive identical values.

Test Plan:
- R-type (opcode 0110011), rs1=3, rs2=5, regfile x3=0x11, x5=0x22.
  - rf_raddr=3 in cycle 1 and 5 in cycle 2.
  - out_valid in cycle 3 with rs1_data=0x11, rs2_data=0x22.
- I-type op-imm (0010011), rs1=7 (x7=0xABCD).
  - Exactly one read cycle; out_valid 2 cycles after acceptance.
  - rs1_data=0xABCD, rs2_data=0.
- lui (0110111), then R-type with rs1=0, rs2=0.
  - No rf_re pulses for either instruction.
  - out_valid 1 cycle after each acceptance; both operands 0.
- R-type rs1=4 with wb_en, wb_addr=4, wb_data=0x55 during RD1 (rf_rdata=0x99) -> rs1_data=0x55.
- R-type held in HOLD with out_ready=0, wb_en to rs2's register with 0x77 -> rs2_data=0x77 before handshake.
  - Then out_ready=1 -> IDLE; in_ready high the next cycle.
- rst driven low during RD2 -> next cycle:
  - state IDLE, out_valid=0, rf_re=0, operands 0.
  - A new instruction is accepted cleanly after rst returns high.
